// File: rtl/vga_scan_gen_if.sv
// Raster-position bundle between the VGA scan generator (master) and the
// sprite/title renderers (slave).
interface vga_scan_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       hsync;
    logic       vsync;
    logic       blank;
    logic       frame_start;
    logic       line_start;

    modport master (
        output DrawX,
        output DrawY,
        output hsync,
        output vsync,
        output blank,
        output frame_start,
        output line_start
    );

    modport slave (
        input DrawX,
        input DrawY,
        input hsync,
        input vsync,
        input blank,
        input frame_start,
        input line_start
    );
endinterface

// File: rtl/vga_scan_gen.sv
// VGA raster timing generator: hsync/vsync/blank and DrawX/DrawY on vga_clk.
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync by SYNC_DELAY clocks to match renderer latency.
module vga_scan_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic            vga_clk,
    input  logic            reset_n,
    vga_scan_gen_if.master  vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_scan_gen: H_TOTAL/V_TOTAL must fit a 10-bit counter");
        end
    endgenerate

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic [9:0] hc_p0;
    logic [9:0] vc_p0;

    logic [9:0] draw_x_p1;
    logic [9:0] draw_y_p1;
    logic       hsync_p1;
    logic       vsync_p1;
    logic       blank_p1;
    logic       frame_start_p1;
    logic       line_start_p1;

    // Stage p0: free-running pixel/line counters
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc_p0 <= '0;
            vc_p0 <= '0;
        end else if (hc_p0 == H_LAST) begin
            hc_p0 <= '0;
            vc_p0 <= (vc_p0 == V_LAST) ? '0 : vc_p0 + 10'd1;
        end else begin
            hc_p0 <= hc_p0 + 10'd1;
        end
    end

    // Stage p1: registered decode of the pre-increment counters
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x_p1      <= '0;
            draw_y_p1      <= '0;
            hsync_p1       <= 1'b1;
            vsync_p1       <= 1'b1;
            blank_p1       <= 1'b0;
            frame_start_p1 <= 1'b0;
            line_start_p1  <= 1'b0;
        end else begin
            draw_x_p1      <= hc_p0;
            draw_y_p1      <= vc_p0;
            hsync_p1       <= ~in_window(hc_p0, HS_FIRST, HS_LAST);
            vsync_p1       <= ~in_window(vc_p0, VS_FIRST, VS_LAST);
            blank_p1       <= (hc_p0 < H_VIS) && (vc_p0 < V_VIS);
            frame_start_p1 <= (hc_p0 == '0) && (vc_p0 == '0);
            line_start_p1  <= (hc_p0 == '0);
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    generate
        if (SYNC_DELAY < 1) begin : g_bad_delay
            $error("vga_scan_gen: SYNC_DELAY must be at least 1");
        end
    endgenerate

    logic [SYNC_DELAY-1:0] hs_dly_p2;
    logic [SYNC_DELAY-1:0] vs_dly_p2;

    // Stage p2: sync shift register, idles high so no spurious pulse after reset
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly_p2 <= '1;
            vs_dly_p2 <= '1;
        end else begin
            hs_dly_p2[0] <= hsync_p1;
            vs_dly_p2[0] <= vsync_p1;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                hs_dly_p2[i] <= hs_dly_p2[i-1];
                vs_dly_p2[i] <= vs_dly_p2[i-1];
            end
        end
    end

    assign vga.hsync = hs_dly_p2[SYNC_DELAY-1];
    assign vga.vsync = vs_dly_p2[SYNC_DELAY-1];
`else
    generate
        if (SYNC_DELAY < 0) begin : g_bad_delay
            $error("vga_scan_gen: SYNC_DELAY must not be negative");
        end
    endgenerate

    assign vga.hsync = hsync_p1;
    assign vga.vsync = vsync_p1;
`endif

    assign vga.DrawX       = draw_x_p1;
    assign vga.DrawY       = draw_y_p1;
    assign vga.blank       = blank_p1;
    assign vga.frame_start = frame_start_p1;
    assign vga.line_start  = line_start_p1;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a full-size instance for line timing and a shrunken
// instance (32x20 raster) for frame-level timing, wrap and mid-frame reset.
module tb_vga_scan_gen;

    localparam int NE = 2000;
`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = 2;
`else
    localparam int SD = 0;
`endif

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    always #20 vga_clk = ~vga_clk;

    vga_scan_gen_if if_full ();
    vga_scan_gen_if if_small ();

    vga_scan_gen u_full (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (if_full.master)
    );

    vga_scan_gen #(
        .H_VISIBLE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
        .V_VISIBLE (12), .V_FRONT (2), .V_SYNC (2), .V_BACK (4),
        .SYNC_DELAY(2)
    ) u_small (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .vga     (if_small.master)
    );

    typedef struct {
        int sm;  // 0 = full-size instance, 1 = small instance
        int e;   // rising edge number after reset release
        int x, y, hs, vs, bl, fs, ls;
    } vec_t;

    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    int hx [0:1][0:NE];
    int hy [0:1][0:NE];
    int hh [0:1][0:NE];
    int hv [0:1][0:NE];
    int hb [0:1][0:NE];
    int hf [0:1][0:NE];
    int hl [0:1][0:NE];

    int hlo [0:1] = '{656, 20};
    int hhi [0:1] = '{751, 25};
    int vlo [0:1] = '{490, 14};
    int vhi [0:1] = '{491, 15};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic sample(input int d, input int e);
        if (d == 0) begin
            hx[0][e] = int'(if_full.DrawX);  hy[0][e] = int'(if_full.DrawY);
            hh[0][e] = int'(if_full.hsync);  hv[0][e] = int'(if_full.vsync);
            hb[0][e] = int'(if_full.blank);  hf[0][e] = int'(if_full.frame_start);
            hl[0][e] = int'(if_full.line_start);
        end else begin
            hx[1][e] = int'(if_small.DrawX); hy[1][e] = int'(if_small.DrawY);
            hh[1][e] = int'(if_small.hsync); hv[1][e] = int'(if_small.vsync);
            hb[1][e] = int'(if_small.blank); hf[1][e] = int'(if_small.frame_start);
            hl[1][e] = int'(if_small.line_start);
        end
    endtask

    task automatic run_edges(input int n);
        for (int e = 1; e <= n; e++) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            sample(0, e);
            sample(1, e);
        end
    endtask

    task automatic chk_now(input string tag, input int d, input int x, input int y,
                           input int hs, input int vs, input int bl, input int fs, input int ls);
        sample(d, 0);
        chk({tag, "_x"},  hx[d][0], x);
        chk({tag, "_y"},  hy[d][0], y);
        chk({tag, "_hs"}, hh[d][0], hs);
        chk({tag, "_vs"}, hv[d][0], vs);
        chk({tag, "_bl"}, hb[d][0], bl);
        chk({tag, "_fs"}, hf[d][0], fs);
        chk({tag, "_ls"}, hl[d][0], ls);
    endtask

    initial begin
        int cnt, viol, prev, found, lo, hi;
        string nm;

        //             sm  e     x    y  hs vs bl fs ls
        tbl.push_back('{0, 1,    0,   0, 1, 1, 1, 1, 1});
        tbl.push_back('{0, 2,    1,   0, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 640,  639, 0, 1, 1, 1, 0, 0});
        tbl.push_back('{0, 641,  640, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 656,  655, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 657,  656, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 752,  751, 0, 0, 1, 0, 0, 0});
        tbl.push_back('{0, 753,  752, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 800,  799, 0, 1, 1, 0, 0, 0});
        tbl.push_back('{0, 801,  0,   1, 1, 1, 1, 0, 1});
        tbl.push_back('{0, 1601, 0,   2, 1, 1, 1, 0, 1});
        tbl.push_back('{1, 1,    0,   0, 1, 1, 1, 1, 1});
        tbl.push_back('{1, 17,   16,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 21,   20,  0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 26,   25,  0, 0, 1, 0, 0, 0});
        tbl.push_back('{1, 27,   26,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 32,   31,  0, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 33,   0,   1, 1, 1, 1, 0, 1});
        tbl.push_back('{1, 368,  15,  11, 1, 1, 1, 0, 0});
        tbl.push_back('{1, 369,  16,  11, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 385,  0,   12, 1, 1, 0, 0, 1});
        tbl.push_back('{1, 448,  31,  13, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 449,  0,   14, 1, 0, 0, 0, 1});
        tbl.push_back('{1, 470,  21,  14, 0, 0, 0, 0, 0});
        tbl.push_back('{1, 512,  31,  15, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 513,  0,   16, 1, 1, 0, 0, 1});
        tbl.push_back('{1, 640,  31,  19, 1, 1, 0, 0, 0});
        tbl.push_back('{1, 641,  0,   0, 1, 1, 1, 1, 1});
        tbl.push_back('{1, 1281, 0,   0, 1, 1, 1, 1, 1});

        // Held in reset across several edges
        reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        chk_now("rst_full",  0, 0, 0, 1, 1, 0, 0, 0);
        chk_now("rst_small", 1, 0, 0, 1, 1, 0, 0, 0);

        reset_n = 1'b1;
        run_edges(NE);

        foreach (tbl[i]) begin
            int d, e;
            d  = tbl[i].sm;
            e  = tbl[i].e;
            nm = $sformatf("%s_e%0d", (d != 0) ? "small" : "full", e);
            chk({nm, "_x"},  hx[d][e],      tbl[i].x);
            chk({nm, "_y"},  hy[d][e],      tbl[i].y);
            chk({nm, "_hs"}, hh[d][e + SD], tbl[i].hs);
            chk({nm, "_vs"}, hv[d][e + SD], tbl[i].vs);
            chk({nm, "_bl"}, hb[d][e],      tbl[i].bl);
            chk({nm, "_fs"}, hf[d][e],      tbl[i].fs);
            chk({nm, "_ls"}, hl[d][e],      tbl[i].ls);
        end

        // Sync windows keyed off DrawX/DrawY; vsync edges only where DrawX goes to 0
        for (int d = 0; d < 2; d++) begin
            viol = 0;
            for (int e = 1; e <= NE - SD; e++) begin
                lo = ((hx[d][e] >= hlo[d]) && (hx[d][e] <= hhi[d])) ? 0 : 1;
                hi = ((hy[d][e] >= vlo[d]) && (hy[d][e] <= vhi[d])) ? 0 : 1;
                if (hh[d][e + SD] != lo) viol++;
                if (hv[d][e + SD] != hi) viol++;
                if (e >= 2 && hv[d][e + SD] != hv[d][e + SD - 1] && hx[d][e] != 0) viol++;
            end
            chk($sformatf("sync_window_dut%0d", d), viol, 0);
        end

        cnt = 0;
        for (int e = 1 + SD; e <= 800 + SD; e++) if (hh[0][e] == 0) cnt++;
        chk("full_hsync_low_per_line", cnt, 96);
        cnt = 0;
        for (int e = 1; e <= 1600; e++) cnt += hl[0][e];
        chk("full_line_start_2_lines", cnt, 2);
        cnt = 0;
        for (int e = 1; e <= NE; e++) cnt += hf[0][e];
        chk("full_frame_start_count", cnt, 1);

        cnt = 0;
        for (int e = 641; e <= 1280; e++) cnt += hb[1][e];
        chk("small_blank_per_frame", cnt, 192);
        cnt = 0;
        for (int e = 641 + SD; e <= 1280 + SD; e++) if (hv[1][e] == 0) cnt++;
        chk("small_vsync_low_per_frame", cnt, 64);
        cnt = 0;
        for (int e = 641; e <= 1280; e++) cnt += hl[1][e];
        chk("small_line_start_per_frame", cnt, 20);

        cnt = 0;
        prev = 0;
        viol = 0;
        for (int e = 1; e <= NE; e++) begin
            if (hy[1][e] > viol) viol = hy[1][e];
            if (hf[1][e] == 1) begin
                cnt++;
                if (prev != 0) chk($sformatf("small_frame_gap_e%0d", e), e - prev, 640);
                prev = e;
            end
        end
        chk("small_frame_start_count", cnt, 4);
        chk("small_max_drawy", viol, 19);

        // Mid-frame asynchronous reset while both syncs are low
        found = 0;
        for (int k = 0; k < 1000 && found == 0; k++) begin
            @(posedge vga_clk);
            @(negedge vga_clk);
            if (if_small.DrawX == 10'd22 && if_small.DrawY == 10'd15) found = 1;
        end
        chk("midrst_reach_position", found, 1);
        if (found == 1) begin
            chk("midrst_pre_hs", int'(if_small.hsync), 0);
            chk("midrst_pre_vs", int'(if_small.vsync), 0);
        end
        #5 reset_n = 1'b0;
        #1;
        chk_now("midrst_async_small", 1, 0, 0, 1, 1, 0, 0, 0);
        chk_now("midrst_async_full",  0, 0, 0, 1, 1, 0, 0, 0);
        @(negedge vga_clk);
        reset_n = 1'b1;
        run_edges(40);
        chk("restart_small_e1_x",  hx[1][1], 0);
        chk("restart_small_e1_y",  hy[1][1], 0);
        chk("restart_small_e1_fs", hf[1][1], 1);
        chk("restart_full_e1_fs",  hf[0][1], 1);
        chk("restart_full_e1_y",   hy[0][1], 0);
        chk("restart_small_hs_pre",  hh[1][20 + SD], 1);
        chk("restart_small_hs_fall", hh[1][21 + SD], 0);
        chk("restart_small_e40_x", hx[1][40], 7);
        chk("restart_small_e40_y", hy[1][40], 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
